// File: rtl/pause_pkg.sv
// Shared state encoding and default parameter values for the pause arbiter.
package pause_pkg;

    localparam int NREQ_DEF        = 4;
    localparam int ACK_TIMEOUT_DEF = 65535;
    localparam int VBL_ALIGN_DEF   = 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SYNC      = 3'd1,
        ST_HALT_WAIT = 3'd2,
        ST_GRANT     = 3'd3,
        ST_ARB       = 3'd4
    } pause_state_t;

    // Width of an index into NREQ requesters, never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin picker: first pending request after last_grant, wrapping.
module rr_select
    import pause_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int LGW  = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [LGW-1:0]  last_grant,
    output logic [NREQ-1:0] sel,
    output logic            valid
);

    logic [LGW-1:0] idx;
    logic           found;

    // Scan NREQ slots starting one past the previous owner; take the first hit.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = LGW'((int'(last_grant) + i) % NREQ);
            if (!found && req[idx]) begin
                sel[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/pause_arbiter.sv
// Pauses the CPU (optionally aligned to vblank), waits for halt_ack, then
// hands the bus to one requester at a time in round-robin order.
module pause_arbiter
    import pause_pkg::*;
#(
    parameter int NREQ        = NREQ_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter int VBL_ALIGN   = VBL_ALIGN_DEF
) (
    input  logic            clk_sys,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            vblank,
    input  logic            halt_ack,
    output logic            pause_req,
    output logic [NREQ-1:0] grant,
    output logic            busy,
    output logic            timeout_err
);

    localparam int LGW = idx_width(NREQ);
    localparam int CW  = ($clog2(ACK_TIMEOUT + 1) < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);

    pause_state_t    state;
    logic [CW-1:0]   cnt;
    logic [LGW-1:0]  last_grant;
    logic            vbl_prev;
    logic            vbl_rise;
    logic [NREQ-1:0] sel;
    logic            sel_valid;
    logic [LGW-1:0]  sel_idx;

    rr_select #(.NREQ(NREQ), .LGW(LGW)) u_rr (
        .req        (req),
        .last_grant (last_grant),
        .sel        (sel),
        .valid      (sel_valid)
    );

    // One-hot selection back to an index for last_grant bookkeeping.
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NREQ; i++)
            if (sel[i]) sel_idx = LGW'(i);
    end

    assign busy = (state != ST_IDLE);

    // Main controller: vblank edge tracking, ack wait with timeout, grant hand-off.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= ST_IDLE;
            pause_req   <= 1'b0;
            grant       <= '0;
            timeout_err <= 1'b0;
            cnt         <= '0;
            last_grant  <= LGW'(NREQ - 1);
            vbl_prev    <= 1'b0;
            vbl_rise    <= 1'b0;
        end else begin
            // Edge is registered so SYNC acts on it one cycle after it is seen.
            vbl_prev <= vblank;
            vbl_rise <= vblank & ~vbl_prev;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        cnt <= '0;
                        if (VBL_ALIGN != 0) begin
                            state <= ST_SYNC;
                        end else begin
                            state     <= ST_HALT_WAIT;
                            pause_req <= 1'b1;
                        end
                    end
                end
                ST_SYNC: begin
                    if (req == '0) begin
                        state <= ST_IDLE;
                    end else if (vbl_rise) begin
                        state     <= ST_HALT_WAIT;
                        pause_req <= 1'b1;
                        cnt       <= '0;
                    end
                end
                ST_HALT_WAIT: begin
                    if (halt_ack) begin
                        state <= ST_ARB;
                        cnt   <= '0;
                    end else if (cnt == CW'(ACK_TIMEOUT)) begin
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                        pause_req   <= 1'b0;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_ARB: begin
                    if (sel_valid) begin
                        grant      <= sel;
                        last_grant <= sel_idx;
                        state      <= ST_GRANT;
                    end else begin
                        state     <= ST_IDLE;
                        pause_req <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    // No preemption: only the owner's release ends the grant.
                    if (!req[last_grant]) begin
                        grant <= '0;
                        state <= ST_ARB;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    pause_req <= 1'b0;
                    grant     <= '0;
                end
            endcase
        end
    end

endmodule
